// File: rtl/egress_drain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : egress_drain_ctrl_if
// Brief    : FIFO-read and merged-output bus of the egress drain controller.
// Revision : 1.0 - initial release
// ============================================================================
interface egress_drain_ctrl_if #(
    parameter int DATA_W = 6
);
    logic              empty_d0;
    logic              empty_d1;
    logic [DATA_W-1:0] data_d0;
    logic [DATA_W-1:0] data_d1;
    logic              pop_D0;
    logic              pop_D1;
    logic [DATA_W-1:0] data_out;
    logic              dest_out;
    logic              valid_out;
    logic              out_ready;

    modport master (
        input  empty_d0, empty_d1, data_d0, data_d1, out_ready,
        output pop_D0, pop_D1, data_out, dest_out, valid_out
    );

    modport slave (
        output empty_d0, empty_d1, data_d0, data_d1, out_ready,
        input  pop_D0, pop_D1, data_out, dest_out, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/egress_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : egress_drain_ctrl
// Brief    : Pops destination FIFOs D0/D1 and merges them into one valid/ready
//            stream via a 2-entry buffer. Option macro: EGRESS_STRICT_PRIO_EN
// Revision : 1.0 - initial release
// ============================================================================
module egress_drain_ctrl #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    egress_drain_ctrl_if.master bus,
    output logic                idle_out,
    output logic                active_out,
    output logic [CNT_W-1:0]    cnt_d0,
    output logic [CNT_W-1:0]    cnt_d1
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam int               c_ENT_W   = DATA_W + 1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t               state_q, state_d;
    logic                 rr_q, rr_d;
    logic [1:0]           occ_q, occ_d;
    logic [c_ENT_W-1:0]   head_q, head_d;
    logic [c_ENT_W-1:0]   tail_q, tail_d;
    logic                 infl_v_q, infl_v_d;
    logic                 infl_src_q, infl_src_d;
    logic [CNT_W-1:0]     cnt0_q, cnt0_d;
    logic [CNT_W-1:0]     cnt1_q, cnt1_d;

    logic                 w_deq;
    logic [2:0]           w_level;
    logic                 w_can_pop;
    logic                 w_pop0;
    logic                 w_pop1;
    logic                 w_any_data;
    logic [1:0]           w_occ_after;
    logic [c_ENT_W-1:0]   w_new;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            infl_v_q   <= 1'b0;
            infl_src_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            infl_v_q   <= infl_v_d;
            infl_src_q <= infl_src_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    // Pop only if the word can still land: buffered + in flight - leaving < 2.
    always_comb begin
        w_deq      = (occ_q != 2'd0) && bus.out_ready;
        w_level    = {1'b0, occ_q} + {2'b00, infl_v_q} - {2'b00, w_deq};
        w_can_pop  = (state_q == ST_ACTIVE) && enable && (w_level < 3'd2);
        w_any_data = !bus.empty_d0 || !bus.empty_d1;
`ifdef EGRESS_STRICT_PRIO_EN
        w_pop0 = w_can_pop && !bus.empty_d0;
        w_pop1 = w_can_pop && bus.empty_d0 && !bus.empty_d1;
        rr_d   = rr_q;
`else
        w_pop0 = w_can_pop && !bus.empty_d0 && (bus.empty_d1 || !rr_q);
        w_pop1 = w_can_pop && !bus.empty_d1 && (bus.empty_d0 || rr_q);
        rr_d   = (w_can_pop && !bus.empty_d0 && !bus.empty_d1) ? ~rr_q : rr_q;
`endif
        infl_v_d   = w_pop0 || w_pop1;
        infl_src_d = w_pop1;
    end

    // Dequeue shifts first; the captured word then lands behind what remains.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        w_new       = {infl_src_q, infl_src_q ? bus.data_d1 : bus.data_d0};
        w_occ_after = occ_q - {1'b0, w_deq};
        if (w_deq) begin
            head_d = tail_q;
        end
        if (infl_v_q) begin
            if (w_occ_after == 2'd0) begin
                head_d = w_new;
            end else begin
                tail_d = w_new;
            end
        end
        occ_d = w_occ_after + {1'b0, infl_v_q};
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (w_deq && !head_q[DATA_W] && (cnt0_q != c_CNT_MAX)) begin
            cnt0_d = cnt0_q + c_CNT_ONE;
        end
        if (w_deq && head_q[DATA_W] && (cnt1_q != c_CNT_MAX)) begin
            cnt1_d = cnt1_q + c_CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && w_any_data) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!enable || !w_any_data) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (enable && w_any_data) begin
                    state_d = ST_ACTIVE;
                end else if ((occ_q == 2'd0) && !infl_v_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.pop_D0    = w_pop0;
    assign bus.pop_D1    = w_pop1;
    assign bus.data_out  = head_q[DATA_W-1:0];
    assign bus.dest_out  = head_q[DATA_W];
    assign bus.valid_out = (occ_q != 2'd0);
    assign idle_out      = (state_q == ST_IDLE) && (occ_q == 2'd0) && !infl_v_q;
    assign active_out    = (state_q == ST_ACTIVE);
    assign cnt_d0        = cnt0_q;
    assign cnt_d1        = cnt1_q;
endmodule
`default_nettype wire

// File: tb/tb_egress_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_egress_drain_ctrl
// Brief    : Directed self-checking bench for egress_drain_ctrl with FIFO models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_egress_drain_ctrl;
    localparam int DATA_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic ordy = 1'b0;

    logic [DATA_W-1:0] mem0 [0:15];
    logic [DATA_W-1:0] mem1 [0:15];
    logic [3:0] rd0 = 4'd0, wr0 = 4'd0, rd1 = 4'd0, wr1 = 4'd0;
    logic [DATA_W-1:0] dd0 = '0, dd1 = '0;

    logic [7:0] cnt0, cnt1;
    logic [1:0] sat0, sat1;
    logic idle, active, sat_idle, sat_active;

    egress_drain_ctrl_if #(.DATA_W(DATA_W)) bus ();
    egress_drain_ctrl_if #(.DATA_W(DATA_W)) bus_sat ();

    assign bus.empty_d0      = (rd0 == wr0);
    assign bus.empty_d1      = (rd1 == wr1);
    assign bus.data_d0       = dd0;
    assign bus.data_d1       = dd1;
    assign bus.out_ready     = ordy;
    assign bus_sat.empty_d0  = bus.empty_d0;
    assign bus_sat.empty_d1  = bus.empty_d1;
    assign bus_sat.data_d0   = dd0;
    assign bus_sat.data_d1   = dd1;
    assign bus_sat.out_ready = ordy;

    egress_drain_ctrl #(.DATA_W(DATA_W), .CNT_W(8)) dut (
        .clk(clk), .reset(rst), .enable(en), .bus(bus),
        .idle_out(idle), .active_out(active), .cnt_d0(cnt0), .cnt_d1(cnt1)
    );

    egress_drain_ctrl #(.DATA_W(DATA_W), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(rst), .enable(en), .bus(bus_sat),
        .idle_out(sat_idle), .active_out(sat_active), .cnt_d0(sat0), .cnt_d1(sat1)
    );

    always #5 clk = ~clk;

    // FIFO models: registered read data, valid the cycle after the pop.
    always @(posedge clk) begin
        if (bus.pop_D0 && (rd0 != wr0)) begin
            dd0 <= mem0[rd0];
            rd0 <= rd0 + 4'd1;
        end
        if (bus.pop_D1 && (rd1 != wr1)) begin
            dd1 <= mem1[rd1];
            rd1 <= rd1 + 4'd1;
        end
    end

    int tests = 0;
    int fails = 0;
    int pops0 = 0, pops1 = 0, viol_empty = 0, viol_overlap = 0;
    int cyc = 0, first_pop = -1, last_pop = -1, first_out = -1, last_out = -1;
    logic [DATA_W:0] outq [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.pop_D0) begin
            pops0 = pops0 + 1;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (bus.pop_D1) pops1 = pops1 + 1;
        if ((bus.pop_D0 && bus.empty_d0) || (bus.pop_D1 && bus.empty_d1))
            viol_empty = viol_empty + 1;
        if (bus.pop_D0 && bus.pop_D1) viol_overlap = viol_overlap + 1;
        if (bus.valid_out && bus.out_ready) begin
            outq.push_back({bus.dest_out, bus.data_out});
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        pops0 = 0; pops1 = 0; viol_empty = 0; viol_overlap = 0;
        first_pop = -1; last_pop = -1; first_out = -1; last_out = -1;
        outq.delete();
    endtask

    task automatic do_reset();
        en = 1'b0;
        ordy = 1'b0;
        rst = 1'b1;
        wr0 = rd0;
        wr1 = rd1;
        step();
        step();
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic load0(input logic [DATA_W-1:0] w);
        mem0[wr0] = w;
        wr0 = wr0 + 4'd1;
    endtask

    task automatic load1(input logic [DATA_W-1:0] w);
        mem1[wr1] = w;
        wr1 = wr1 + 4'd1;
    endtask

    task automatic wait_idle(input int min_cyc, output bit ok);
        ok = 1'b0;
        repeat (min_cyc) step();
        for (int i = 0; i < 100; i++) begin
            if (idle) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++; if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", bus.valid_out); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %0b want 1", idle); end
        tests++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active: got %0b want 0", active); end
        tests++; if ({bus.pop_D0, bus.pop_D1} !== 2'b00) begin fails++; $display("FAIL reset_pops: got %b want 00", {bus.pop_D0, bus.pop_D1}); end
        tests++; if ({cnt0, cnt1} !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %h want 0000", {cnt0, cnt1}); end
        tests++; if ({bus.data_out, bus.dest_out} !== 7'h0) begin fails++; $display("FAIL reset_data: got %h want 00", {bus.data_out, bus.dest_out}); end
        do_reset();
    endtask

    task automatic test_single_stream();
        bit ok;
        do_reset();
        for (int i = 1; i <= 4; i++) load0(DATA_W'(i));
        en = 1'b1; ordy = 1'b1;
        wait_idle(4, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL single_idle: got timeout want idle_out=1"); end
        tests++; if (pops0 !== 4 || pops1 !== 0) begin fails++; $display("FAIL single_pops: got %0d/%0d want 4/0", pops0, pops1); end
        tests++; if (last_pop - first_pop !== 3) begin fails++; $display("FAIL single_pop_run: got span %0d want 3", last_pop - first_pop); end
        tests++; if (last_out - first_out !== 3 || first_out <= first_pop) begin fails++; $display("FAIL single_out_run: got span %0d want 3", last_out - first_out); end
        tests++; if (outq.size() !== 4) begin fails++; $display("FAIL single_count: got %0d want 4", outq.size()); end
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            tests++; if (outq[i] !== {1'b0, DATA_W'(i + 1)}) begin fails++; $display("FAIL single_word%0d: got %h want %h", i, outq[i], {1'b0, DATA_W'(i + 1)}); end
        end
        tests++; if (cnt0 !== 8'd4 || cnt1 !== 8'd0) begin fails++; $display("FAIL single_cnt: got %0d/%0d want 4/0", cnt0, cnt1); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [DATA_W:0] exp [4];
`ifdef EGRESS_STRICT_PRIO_EN
        exp = '{7'h10, 7'h11, 7'h60, 7'h61};
`else
        exp = '{7'h10, 7'h60, 7'h11, 7'h61};
`endif
        do_reset();
        load0(6'h10); load0(6'h11);
        load1(6'h20); load1(6'h21);
        en = 1'b1; ordy = 1'b1;
        wait_idle(4, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rr_idle: got timeout want idle_out=1"); end
        tests++; if (outq.size() !== 4) begin fails++; $display("FAIL rr_count: got %0d want 4", outq.size()); end
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            tests++; if (outq[i] !== exp[i]) begin fails++; $display("FAIL rr_word%0d: got %h want %h", i, outq[i], exp[i]); end
        end
        tests++; if (viol_overlap !== 0) begin fails++; $display("FAIL rr_overlap: got %0d want 0", viol_overlap); end
        tests++; if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin fails++; $display("FAIL rr_cnt: got %0d/%0d want 2/2", cnt0, cnt1); end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) load0(DATA_W'(6'h30 + i));
        en = 1'b1; ordy = 1'b0;
        repeat (8) step();
        tests++; if (pops0 !== 2) begin fails++; $display("FAIL bp_pops: got %0d want 2", pops0); end
        tests++; if (bus.pop_D0 !== 1'b0) begin fails++; $display("FAIL bp_pop_now: got %0b want 0", bus.pop_D0); end
        tests++; if (bus.valid_out !== 1'b1 || bus.data_out !== 6'h30) begin fails++; $display("FAIL bp_head: got v=%0b d=%h want v=1 d=30", bus.valid_out, bus.data_out); end
        ordy = 1'b1;
        wait_idle(2, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL bp_idle: got timeout want idle_out=1"); end
        tests++; if (outq.size() !== 5 || pops0 !== 5) begin fails++; $display("FAIL bp_count: got %0d words %0d pops want 5/5", outq.size(), pops0); end
        for (int i = 0; i < 5 && i < outq.size(); i++) begin
            tests++; if (outq[i] !== {1'b0, DATA_W'(6'h30 + i)}) begin fails++; $display("FAIL bp_word%0d: got %h want %h", i, outq[i], {1'b0, DATA_W'(6'h30 + i)}); end
        end
    endtask

    task automatic test_empty_edge();
        int phase = 0;
        do_reset();
        load1(6'h2A); load1(6'h2B);
        en = 1'b1; ordy = 1'b1;
        for (int i = 0; i < 40 && phase != 3; i++) begin
            step();
            if (phase == 0 && active) phase = 1;
            else if (phase == 1 && !active && !idle) phase = 2;
            else if (phase == 2 && active) phase = 9;
            else if (phase == 2 && idle) phase = 3;
        end
        tests++; if (phase !== 3) begin fails++; $display("FAIL empty_fsm_seq: got phase %0d want 3", phase); end
        tests++; if (viol_empty !== 0) begin fails++; $display("FAIL empty_pop: got %0d want 0", viol_empty); end
        tests++; if (outq.size() !== 2 || outq[0] !== 7'h6A || outq[1] !== 7'h6B) begin fails++; $display("FAIL empty_words: got %0d words want 6a,6b", outq.size()); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit hit = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) load0(DATA_W'(6'h08 + i));
        en = 1'b1; ordy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pops0 == 2) begin
                hit = 1'b1;
                break;
            end
        end
        tests++; if (hit !== 1'b1) begin fails++; $display("FAIL endrop_setup: got timeout want 2 pops"); end
        en = 1'b0; ordy = 1'b1;
        wait_idle(2, ok);
        tests++; if (ok !== 1'b1 || idle !== 1'b1) begin fails++; $display("FAIL endrop_idle: got %0b want 1", idle); end
        tests++; if (pops0 !== 2) begin fails++; $display("FAIL endrop_pops: got %0d want 2", pops0); end
        tests++; if (outq.size() !== 2 || outq[0] !== 7'h08 || outq[1] !== 7'h09) begin fails++; $display("FAIL endrop_words: got %0d words want 08,09", outq.size()); end
    endtask

    task automatic test_async_reset();
        bit hit = 1'b0;
        do_reset();
        for (int i = 1; i <= 8; i++) load0(DATA_W'(i));
        en = 1'b1; ordy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (outq.size() >= 5) begin
                hit = 1'b1;
                break;
            end
        end
        tests++; if (hit !== 1'b1) begin fails++; $display("FAIL areset_setup: got timeout want 5 words"); end
        tests++; if (cnt0 !== 8'd5) begin fails++; $display("FAIL areset_cnt_pre: got %0d want 5", cnt0); end
        tests++; if (sat0 !== 2'd3) begin fails++; $display("FAIL areset_sat: got %0d want 3", sat0); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.valid_out !== 1'b0 || idle !== 1'b1) begin fails++; $display("FAIL areset_imm: got v=%0b idle=%0b want 0/1", bus.valid_out, idle); end
        tests++; if ({bus.pop_D0, bus.pop_D1} !== 2'b00) begin fails++; $display("FAIL areset_pops: got %b want 00", {bus.pop_D0, bus.pop_D1}); end
        tests++; if (cnt0 !== 8'd0 || sat0 !== 2'd0) begin fails++; $display("FAIL areset_cnt: got %0d/%0d want 0/0", cnt0, sat0); end
        en = 1'b0;
        step();
        rst = 1'b0;
        step();
        tests++; if (idle !== 1'b1 || bus.valid_out !== 1'b0 || cnt0 !== 8'd0) begin fails++; $display("FAIL areset_after: got idle=%0b v=%0b cnt=%0d want 1/0/0", idle, bus.valid_out, cnt0); end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_backpressure();
        test_empty_edge();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
